// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory access unit: FSM states and access size.
// No logic; no latency; no backpressure.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } mem_state_t;

    typedef enum logic {
        WORD = 1'b0,
        BYTE = 1'b1
    } lc3b_mem_size;

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and memory-port bundle for mem_access_unit.
// Wires only; no latency; the handshake is req_valid/req_ready, memory completion is mem_resp.
interface mem_access_unit_if #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic                    req_byte;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [WIDTH-1:0]        req_wdata;
    logic                    resp_valid;
    logic [WIDTH-1:0]        resp_rdata;
    logic                    resp_err;
    logic                    mem_read;
    logic                    mem_write;
    logic [ADDR_WIDTH-1:0]   mem_address;
    logic [WIDTH-1:0]        mem_wdata;
    logic [WIDTH/8-1:0]      mem_byte_enable;
    logic                    mem_resp;
    logic [WIDTH-1:0]        mem_rdata;

    // The unit itself: takes requests, drives the memory port.
    modport slave (
        input  req_valid, req_write, req_byte, req_addr, req_wdata, mem_resp, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
    );

    // The environment: issues requests and plays the memory.
    modport master (
        output req_valid, req_write, req_byte, req_addr, req_wdata, mem_resp, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
    );
endinterface

// File: rtl/mem_access_unit_byte_lane_align.sv
// Byte-lane steering: store replication, lane enables, load select with zero-extend.
// Combinational, zero latency; no backpressure.
module byte_lane_align
    import mem_access_unit_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int NL   = WIDTH / 8,
    localparam int LB   = $clog2(NL)
) (
    input  lc3b_mem_size     st_size_i,
    input  logic [LB-1:0]    st_lane_i,
    input  logic [WIDTH-1:0] st_wdata_i,
    output logic [WIDTH-1:0] st_wdata_o,
    output logic [NL-1:0]    st_be_o,
    input  lc3b_mem_size     ld_size_i,
    input  logic [LB-1:0]    ld_lane_i,
    input  logic [WIDTH-1:0] ld_rdata_i,
    output logic [WIDTH-1:0] ld_rdata_o
);
    logic [WIDTH-1:0] ld_shifted;

    always_comb begin
        st_wdata_o = st_wdata_i;
        st_be_o    = '1;
        if (st_size_i == BYTE) begin
            st_wdata_o = {NL{st_wdata_i[7:0]}};
            st_be_o    = NL'(1) << st_lane_i;
        end
    end

    always_comb begin
        ld_shifted = ld_rdata_i >> {ld_lane_i, 3'b000};
        ld_rdata_o = ld_rdata_i;
        if (ld_size_i == BYTE) begin
            ld_rdata_o = {{(WIDTH-8){1'b0}}, ld_shifted[7:0]};
        end
    end
endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit with byte lanes, misalignment check and wait-state timeout.
// Latency: accept -> ACCESS next cycle, resp_valid one cycle after mem_resp; misaligned responds in 1.
// Backpressure: req_ready only in IDLE; memory stalls by withholding mem_resp until TIMEOUT.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_unit_if.slave bus
);
    localparam int NL = WIDTH / 8;
    localparam int LB = $clog2(NL);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    mem_state_t             state_q, state_d;
    logic                   write_q, write_d;
    lc3b_mem_size           size_q, size_d;
    logic [LB-1:0]          lane_q, lane_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  mar_q, mar_d;
    logic [WIDTH-1:0]       mdr_q, mdr_d;
    logic [NL-1:0]          be_q, be_d;
    logic [WIDTH-1:0]       rdata_q, rdata_d;
    logic                   err_q, err_d;

    lc3b_mem_size           req_size;
    logic [LB-1:0]          req_lane;
    logic [WIDTH-1:0]       st_wdata;
    logic [NL-1:0]          st_be;
    logic [WIDTH-1:0]       ld_rdata;

    assign req_size = lc3b_mem_size'(bus.req_byte);
    assign req_lane = bus.req_addr[LB-1:0];

    byte_lane_align #(.WIDTH(WIDTH)) u_align (
        .st_size_i  (req_size),
        .st_lane_i  (req_lane),
        .st_wdata_i (bus.req_wdata),
        .st_wdata_o (st_wdata),
        .st_be_o    (st_be),
        .ld_size_i  (size_q),
        .ld_lane_i  (lane_q),
        .ld_rdata_i (bus.mem_rdata),
        .ld_rdata_o (ld_rdata)
    );

    // Strobes decode from the async-reset state, so they drop the moment rst_n falls.
    assign bus.req_ready       = (state_q == IDLE);
    assign bus.resp_valid      = (state_q == RESP);
    assign bus.resp_err        = (state_q == RESP) && err_q;
    assign bus.resp_rdata      = rdata_q;
    assign bus.mem_read        = (state_q == ACCESS) && !write_q;
    assign bus.mem_write       = (state_q == ACCESS) && write_q;
    assign bus.mem_address     = mar_q;
    assign bus.mem_wdata       = mdr_q;
    assign bus.mem_byte_enable = be_q;

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        size_d  = size_q;
        lane_d  = lane_q;
        cnt_d   = cnt_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    mar_d   = bus.req_addr;
                    mdr_d   = st_wdata;
                    be_d    = st_be;
                    write_d = bus.req_write;
                    size_d  = req_size;
                    lane_d  = req_lane;
                    cnt_d   = '0;
                    if (req_size == WORD && req_lane != '0) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                // mem_resp takes priority over a coincident timeout.
                if (bus.mem_resp) begin
                    if (!write_q) rdata_d = ld_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            size_q  <= WORD;
            lane_q  <= '0;
            cnt_q   <= '0;
            mar_q   <= '0;
            mdr_q   <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            size_q  <= size_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised successor to the datapath's fixed 16-bit MAR/MDR memory path.
- Accepts one load/store request at a time from the control/datapath side with a valid/ready handshake.
- Drives the memory port and waits for mem_resp; returns read data or an error flag.
- Adds byte-lane access (LDB/STB style), misalignment detection and a wait-state timeout, none of which the current path has.

Parameters:
- WIDTH, 16, data width in bits; legal values 16 or 32.
- ADDR_WIDTH, 16, address width in bits.
- TIMEOUT, 64, maximum number of ACCESS cycles before an error response; must be >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access, 0 = full word.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  WIDTH  store data; byte stores use bits [7:0].
- resp_valid  out  1  one-cycle pulse; response is complete.
- resp_rdata  out  WIDTH  load data; byte loads are zero-extended.
- resp_err  out  1  qualifies resp_valid; misaligned access or timeout.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_address  out  ADDR_WIDTH  registered address (MAR).
- mem_wdata  out  WIDTH  registered store data (MDR).
- mem_byte_enable  out  WIDTH/8  active-high lane enables.
- mem_resp  in  1  memory has completed the access.
- mem_rdata  in  WIDTH  memory read data.

Behaviour:
- Definitions: LB = log2(WIDTH/8). lane = req_addr[LB-1:0].
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_read=0; mem_write=0; mem_address=0; mem_wdata=0; mem_byte_enable=0; counter=0.
- Reset applies immediately, including mid-access: strobes drop asynchronously and any in-flight access is abandoned with no response.
- States: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. A request is accepted when req_valid && req_ready. On acceptance:
  - Latch the address into MAR.
  - Latch the store data into MDR. Byte stores replicate req_wdata[7:0] into every lane.
  - Byte enables: a byte access enables only bit [lane]; a word access enables all bits.
  - Latch write/byte/lane into internal registers.
  - Clear the counter.
  - Word access with lane != 0: misaligned. Go to RESP with the error set; no memory strobe is ever asserted.
  - Otherwise go to ACCESS.
- ACCESS: req_ready=0. mem_read = !write and mem_write = write, both held steady; address, wdata and enables are stable.
  - Counter increments every cycle.
  - On mem_resp: for a load, capture mem_rdata into the read register. A byte load selects lane bits [8*lane+7 : 8*lane] and zero-extends. Go to RESP with err=0.
  - If counter == TIMEOUT-1 and mem_resp is absent: go to RESP with err=1 and read data 0.
  - mem_resp and timeout in the same cycle: mem_resp wins; no error.
- RESP: resp_valid=1 for exactly one cycle with resp_rdata/resp_err valid; strobes low; req_ready=0; next state IDLE.
- resp_rdata holds its value after the pulse until the next response. resp_err is 0 outside RESP.
- mem_resp is ignored in IDLE and RESP; a stray mem_resp causes no state change.
- Latency:
  - Accept at edge 0, ACCESS from cycle 1.
  - Zero-wait memory (mem_resp in the first ACCESS cycle) gives resp_valid in cycle 2.
  - Each memory wait state adds one cycle.
  - A misaligned request gives resp_valid in cycle 1.
- Back-to-back throughput: the next request can be accepted in the cycle after RESP.

Decomposition:
- Add to the lc3b_types package: mem_state_t enum {IDLE, ACCESS, RESP} and the lc3b_mem_size type (WORD/BYTE).
- MAR and MDR reuse the existing parametrised register module at WIDTH/ADDR_WIDTH.
- One new sub-module, byte_lane_align (combinational): store-lane replication, enable generation, load-lane select with zero-extend. Shared with a future cache front end.

Test Plan:
- Word load, WIDTH=16, addr 0x3000, mem_rdata 0xBEEF, mem_resp in first ACCESS cycle -> mem_read high 1 cycle, mem_address 0x3000, enables 2'b11, resp_valid in cycle 2, rdata 0xBEEF, err 0.
- Byte store, addr 0x3001, wdata 0x12A5, 3 wait states -> mem_write held 4 cycles, mem_wdata 0xA5A5, enables 2'b10, resp_valid with err 0.
- Byte load, WIDTH=32, addr 0x0003, mem_rdata 0x80FF_1234 -> rdata 0x0000_0080.
- Word load at 0x3001 -> no mem_read ever asserted, resp_valid in cycle 1, err 1.
- TIMEOUT=4, no mem_resp -> strobe high 4 cycles, resp err 1, rdata 0. Separately, mem_resp on the 4th ACCESS cycle -> err 0.
- Assert rst_n low during the 2nd ACCESS cycle -> strobes low immediately, no resp_valid, req_ready=1 after release. A stray mem_resp in IDLE is ignored.
